fpu_share_arbiter: RTL and testbench

FPU_SHARE_ARBITER -- requirements
Module: fpu_share_arbiter

---
 rtl/fpu_arb_pkg.sv | 17 +
 rtl/fpu_share_arbiter_if.sv | 33 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/fpu_share_arbiter.sv | 134 +++++++++++++
 tb/tb_fpu_share_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_arb_pkg.sv
// ---------------------------------------------------------------------------
// fpu_arb_pkg
// Shared definitions for the FP-adder sharing arbiter: FSM state encoding and
// the default operand width / adder latency used by the arbiter and its bus.
// ---------------------------------------------------------------------------
package fpu_arb_pkg;

   localparam int DEFAULT_DATA_W      = 32;   // IEEE-754 single precision
   localparam int DEFAULT_FPU_LATENCY = 20;   // cycles from stable operands to sum

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // arbitrating, req_ready live
      WAIT = 2'd1,   // operation in the adder, counting latency
      RESP = 2'd2    // one-cycle result strobe to the owner
   } arb_state_e;

endpackage

// File: rtl/fpu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// fpu_share_arbiter_if
// Requester-side bus of the FP-adder sharing arbiter.
//   req_valid  N_REQ           per-requester add request
//   req_a/b    N_REQ x DATA_W  per-requester operands
//   req_ready  N_REQ           one-hot grant/accept
//   rsp_valid  N_REQ           one-hot result strobe to the owning requester
//   rsp_data   DATA_W          sum, qualified by rsp_valid
// master = requesters, slave = arbiter.
// ---------------------------------------------------------------------------
interface fpu_share_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = fpu_arb_pkg::DEFAULT_DATA_W
);

   logic [N_REQ-1:0]  req_valid;
   logic [DATA_W-1:0] req_a [N_REQ];
   logic [DATA_W-1:0] req_b [N_REQ];
   logic [N_REQ-1:0]  req_ready;
   logic [N_REQ-1:0]  rsp_valid;
   logic [DATA_W-1:0] rsp_data;

   modport master (
      output req_valid, req_a, req_b,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_a, req_b,
      output req_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant: one-hot grant to the first asserted req
// searching from (last_grant+1) mod N_REQ, wrapping; zero when no req.
//   req         in  N_REQ   request vector
//   last_grant  in  IDX_W   index of the previous winner
//   grant       out N_REQ   one-hot grant
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [N_REQ-1:0] grant
);

   always_comb begin
      logic [IDX_W-1:0] idx;
      logic             found;
      grant = '0;
      found = 1'b0;
      idx   = '0;
      // last_grant itself is visited last, so the previous winner has lowest priority
      for (int k = 1; k <= N_REQ; k++) begin
         idx = IDX_W'((int'(last_grant) + k) % N_REQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fpu_share_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_share_arbiter
// Shares one external FP adder between N_REQ requesters, one operation in
// flight. IDLE grants round-robin; the granted operands are held on fpu_a/b
// while WAIT counts FPU_LATENCY cycles; the sum is captured into rsp_data and
// strobed to the owner for one cycle in RESP. No arithmetic happens here.
// Handshake in cycle T -> rsp_valid in cycle T+FPU_LATENCY+1.
//   CLK         in   rising-edge clock
//   reset       in   synchronous active-high reset
//   bus         slave modport of fpu_share_arbiter_if (requests / responses)
//   fpu_a/b     out  operands to the adder, stable through WAIT and RESP
//   fpu_result  in   adder sum
//   busy        out  high whenever state is not IDLE
// Optional (macro FPU_ARB_STATS_EN):
//   ops_done    out  16-bit count of completed operations, wrapping
//   busy_cycles out  32-bit count of busy cycles, saturating
// ---------------------------------------------------------------------------
module fpu_share_arbiter
   import fpu_arb_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int FPU_LATENCY = DEFAULT_FPU_LATENCY,
   parameter int DATA_W      = DEFAULT_DATA_W
) (
   input  logic              CLK,
   input  logic              reset,
   fpu_share_arbiter_if.slave bus,
   output logic [DATA_W-1:0] fpu_a,
   output logic [DATA_W-1:0] fpu_b,
   input  logic [DATA_W-1:0] fpu_result,
   output logic              busy
`ifdef FPU_ARB_STATS_EN
   ,
   output logic [15:0]       ops_done,
   output logic [31:0]       busy_cycles
`endif
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FPU_LATENCY - 1);
   localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_REQ - 1);

   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [IDX_W-1:0]  owner_q;
   logic [IDX_W-1:0]  last_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic [N_REQ-1:0]  grant;
   logic [IDX_W-1:0]  grant_idx;
   logic [N_REQ-1:0]  ready;
   logic [N_REQ-1:0]  rsp_valid;
   logic              hs;

   rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
      .req       (bus.req_valid),
      .last_grant(last_q),
      .grant     (grant)
   );

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < N_REQ; i++)
         if (grant[i]) grant_idx = IDX_W'(i);
   end

   // grant is only ever set for a valid requester, so any grant in IDLE is a handshake
   assign hs = (state_q == IDLE) && (|grant);

   always_comb begin
      state_d = state_q;
      ready   = '0;
      case (state_q)
         IDLE: begin
            ready = grant;
            if (hs) state_d = WAIT;
         end
         WAIT:    if (cnt_q == CNT_LAST) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rsp_valid = '0;
      if (state_q == RESP) rsp_valid[owner_q] = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         owner_q    <= '0;
         last_q     <= LAST_INIT;
         fpu_a      <= '0;
         fpu_b      <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (hs) begin
               fpu_a   <= bus.req_a[grant_idx];
               fpu_b   <= bus.req_b[grant_idx];
               owner_q <= grant_idx;
               last_q  <= grant_idx;
               cnt_q   <= '0;
            end
            WAIT: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) rsp_data_q <= fpu_result;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = ready;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_data  = rsp_data_q;
   assign busy          = (state_q != IDLE);

`ifdef FPU_ARB_STATS_EN
   always_ff @(posedge CLK) begin
      if (reset) begin
         ops_done    <= '0;
         busy_cycles <= '0;
      end else begin
         if (state_q == RESP) ops_done <= ops_done + 16'd1;
         if (busy && (busy_cycles != 32'hFFFF_FFFF)) busy_cycles <= busy_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpu_share_arbiter
// Directed bench for fpu_share_arbiter (N_REQ=4, FPU_LATENCY=20, DATA_W=32).
// A timing-level model (operation start cycle + fixed latency, round-robin
// pointer) predicts every output each cycle; DUT grant/response events are
// also logged and pinned against hand-computed literals per scenario.
// The adder is a stand-in: a small table of exact single-precision sums,
// integer sum otherwise, delivered through a FPU_LATENCY-1 register pipe.
// Stats outputs are checked when FPU_ARB_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_fpu_share_arbiter;

   localparam int N = 4;
   localparam int L = 20;
   localparam int W = 32;

   logic         CLK = 1'b0;
   logic         reset;
   logic [W-1:0] fpu_a, fpu_b, fpu_result;
   logic         busy;
`ifdef FPU_ARB_STATS_EN
   logic [15:0]  ops_done;
   logic [31:0]  busy_cycles;
`endif

   fpu_share_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

   fpu_share_arbiter #(.N_REQ(N), .FPU_LATENCY(L), .DATA_W(W)) dut (
      .CLK        (CLK),
      .reset      (reset),
      .bus        (bus),
      .fpu_a      (fpu_a),
      .fpu_b      (fpu_b),
      .fpu_result (fpu_result),
      .busy       (busy)
`ifdef FPU_ARB_STATS_EN
      ,
      .ops_done   (ops_done),
      .busy_cycles(busy_cycles)
`endif
   );

   always #5 CLK = ~CLK;

   function automatic logic [W-1:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b);
      case ({a, b})
         {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2=3
         {32'h40000000, 32'h40000000}: return 32'h40800000; // 2+2=4
         {32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1+1=2
         {32'h40400000, 32'h3F800000}: return 32'h40800000; // 3+1=4
         default:                      return a + b;
      endcase
   endfunction

   // external adder: sum visible exactly on the L-th edge after operands settle
   logic [W-1:0] pipe [L-1];
   always @(posedge CLK) begin
      pipe[0] <= fadd(fpu_a, fpu_b);
      for (int k = 1; k < L - 1; k++) pipe[k] <= pipe[k-1];
   end
   assign fpu_result = pipe[L-2];

   int n_chk = 0, n_fail = 0, cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // DUT event logs
   int g_cyc[$], g_idx[$], r_cyc[$], r_idx[$];
   logic [W-1:0] r_data[$];

   // model state
   logic         m_inflight;
   int           m_resp_cyc, m_owner, m_last;
   logic [W-1:0] m_a, m_b, m_sum, m_data;
   logic [15:0]  m_ops;
   logic [31:0]  m_busy_n;

   always @(negedge CLK) begin
      logic [N-1:0] exp_ready, exp_rsp;
      logic         idle;
      cyc++;
      if (reset) begin
         m_inflight = 1'b0; m_resp_cyc = 0; m_owner = 0; m_last = N - 1;
         m_a = '0; m_b = '0; m_sum = '0; m_data = '0; m_ops = '0; m_busy_n = '0;
      end else begin
         idle = !(m_inflight && cyc <= m_resp_cyc);
         exp_ready = '0;
         if (idle)
            for (int k = 1; k <= N; k++) begin
               int j;
               j = (m_last + k) % N;
               if (exp_ready == '0 && bus.req_valid[j]) exp_ready[j] = 1'b1;
            end
         exp_rsp = '0;
         if (m_inflight && cyc == m_resp_cyc) exp_rsp[m_owner] = 1'b1;
         chk("req_ready", bus.req_ready, exp_ready);
         chk("rsp_valid", bus.rsp_valid, exp_rsp);
         chk("rsp_data",  bus.rsp_data,  m_data);
         chk("busy",      busy,          !idle);
         chk("fpu_a",     fpu_a,         m_a);
         chk("fpu_b",     fpu_b,         m_b);
`ifdef FPU_ARB_STATS_EN
         chk("ops_done",    ops_done,    m_ops);
         chk("busy_cycles", busy_cycles, m_busy_n);
`endif
         for (int i = 0; i < N; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin g_cyc.push_back(cyc); g_idx.push_back(i); end
            if (bus.rsp_valid[i]) begin
               r_cyc.push_back(cyc); r_idx.push_back(i); r_data.push_back(bus.rsp_data);
            end
         end
         // advance model across the coming edge
         if (m_inflight && cyc == m_resp_cyc - 1) m_data = m_sum;
         if (m_inflight && cyc == m_resp_cyc) m_ops = m_ops + 16'd1;
         if (!idle && m_busy_n != 32'hFFFF_FFFF) m_busy_n = m_busy_n + 32'd1;
         for (int i = 0; i < N; i++)
            if (exp_ready[i]) begin
               m_owner = i; m_last = i;
               m_a = bus.req_a[i]; m_b = bus.req_b[i]; m_sum = fadd(m_a, m_b);
               m_inflight = 1'b1; m_resp_cyc = cyc + L + 1;
            end
      end
   end

   task automatic drive(input logic [N-1:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         bus.req_valid = v;
         @(posedge CLK); #1;
      end
   endtask

   int pg[7], pr[7];
   task automatic mark(input int k);
      pg[k] = g_idx.size();
      pr[k] = r_idx.size();
   endtask

   initial begin
      reset = 1'b1;
      bus.req_valid = '0;
      bus.req_a[0] = 32'h3F800000; bus.req_b[0] = 32'h40000000;
      bus.req_a[1] = 32'h40000000; bus.req_b[1] = 32'h40000000;
      bus.req_a[2] = 32'h3F800000; bus.req_b[2] = 32'h3F800000;
      bus.req_a[3] = 32'h40400000; bus.req_b[3] = 32'h3F800000;
      repeat (3) @(posedge CLK);
      #1 reset = 1'b0;
      @(negedge CLK);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_fpu_a", fpu_a, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      @(posedge CLK); #1;

      // single request
      mark(0);
      drive(4'b0001, 1); drive(4'b0000, 25);
      // contention from reset
      reset = 1'b1; drive(4'b0000, 2); reset = 1'b0;
      mark(1);
      drive(4'b1111, 89); drive(4'b0000, 25);
      // wrap: make 3 the last winner, then 1001
      mark(2);
      drive(4'b1000, 1); drive(4'b0000, 25);
      drive(4'b1001, 23); drive(4'b0000, 25);
      // withdrawal of 2 while 1 is in flight
      mark(3);
      drive(4'b0010, 1); drive(4'b0000, 4); drive(4'b0100, 5); drive(4'b0000, 25);
      // reset 10 cycles after handshake
      mark(4);
      drive(4'b0001, 1); drive(4'b0000, 9);
      reset = 1'b1; drive(4'b0000, 1); reset = 1'b0;
      @(negedge CLK);
      chk("busy_after_rst", busy, 0);
      @(posedge CLK); #1;
      drive(4'b0000, 25);
      mark(5);
      drive(4'b0100, 1); drive(4'b0000, 25);
      mark(6);

      // single request: same-cycle grant, 21-cycle latency, 1+2=3
      chk("p1_grants", pg[1] - pg[0], 1);
      chk("p1_rsps",   pr[1] - pr[0], 1);
      if (pg[1] - pg[0] == 1 && pr[1] - pr[0] == 1) begin
         chk("p1_grant_idx", g_idx[pg[0]], 0);
         chk("p1_latency", r_cyc[pr[0]] - g_cyc[pg[0]], 21);
         chk("p1_rsp_data", r_data[pr[0]], 32'h40400000);
      end
      // contention: order 0,1,2,3,0, responses 22 apart
      chk("p2_grants", pg[2] - pg[1], 5);
      chk("p2_rsps",   pr[2] - pr[1], 5);
      if (pg[2] - pg[1] == 5 && pr[2] - pr[1] == 5) begin
         for (int i = 0; i < 5; i++) chk("p2_order", g_idx[pg[1]+i], i % 4);
         for (int i = 1; i < 5; i++) chk("p2_spacing", r_cyc[pr[1]+i] - r_cyc[pr[1]+i-1], 22);
         chk("p2_data_r3", r_data[pr[1]+3], 32'h40800000);
      end
      // wrap: 3 (setup), then 0, then 3
      chk("p3_grants", pg[3] - pg[2], 3);
      if (pg[3] - pg[2] == 3) begin
         chk("p3_first",  g_idx[pg[2]+1], 0);
         chk("p3_second", g_idx[pg[2]+2], 3);
      end
      // withdrawal: only requester 1 served
      chk("p4_grants", pg[4] - pg[3], 1);
      chk("p4_rsps",   pr[4] - pr[3], 1);
      if (pg[4] - pg[3] == 1 && pr[4] - pr[3] == 1) begin
         chk("p4_grant_idx", g_idx[pg[3]], 1);
         chk("p4_rsp_idx", r_idx[pr[3]], 1);
         chk("p4_rsp_data", r_data[pr[3]], 32'h40800000);
      end
      // reset abort: no response, next request normal
      chk("p5_abort_grants", pg[5] - pg[4], 1);
      chk("p5_abort_rsps",   pr[5] - pr[4], 0);
      chk("p5_next_rsps",    pr[6] - pr[5], 1);
      if (pr[6] - pr[5] == 1 && pg[6] - pg[5] == 1) begin
         chk("p5_next_idx", r_idx[pr[5]], 2);
         chk("p5_next_latency", r_cyc[pr[5]] - g_cyc[pg[5]], 21);
         chk("p5_next_data", r_data[pr[5]], 32'h40000000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
